// File: rtl/nandy_int_pkg.sv
// Shared definitions for the Nandy interrupt controllers: id-width helper,
// lowest-set-bit search and default vector placement.
package nandy_int_pkg;

   localparam int          MAX_SRC             = 16;
   localparam int          MAX_IDW             = 4;
   localparam int          INT_VSHIFT_DEFAULT  = 2;
   localparam logic [15:0] INT_VECBASE_DEFAULT = 16'hFF00;

   typedef struct packed {
      logic               valid;
      logic [MAX_IDW-1:0] idx;
   } sel_t;

   // Index width for n sources; never zero so single-source builds still have a port.
   function automatic int IDW(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic sel_t lowest_set(input logic [MAX_SRC-1:0] vec);
      sel_t r;
      r = '0;
      for (int i = MAX_SRC - 1; i >= 0; i--) begin
         if (vec[i]) begin
            r.valid = 1'b1;
            r.idx   = MAX_IDW'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/vectored_intcontrol_prio_enc.sv
// Lowest-index-first priority encoder; index is 0 when nothing is requested.
module prio_enc
   import nandy_int_pkg::*;
#(
   parameter int N = 8,
   parameter int W = IDW(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         valid
);

   logic [MAX_SRC-1:0] req_ext;
   sel_t               hit;

   // NOTE: every variable of a combinational block gets a default first, so no path leaves it holding a value (a latch).
   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      hit            = lowest_set(req_ext);
      idx            = W'(hit.idx);
      valid          = hit.valid;
   end

endmodule

// File: rtl/vectored_intcontrol.sv
// Multi-source vectored interrupt controller: synchronise, latch, prioritise and
// substitute the winning vector for the next PC at an instruction boundary.
module vectored_intcontrol
   import nandy_int_pkg::*;
#(
   parameter int              NSRC     = 8,
   parameter int              PCW      = 16,
   parameter logic [NSRC-1:0] EDGEMASK = '1,
   parameter logic [PCW-1:0]  VECBASE  = PCW'(INT_VECBASE_DEFAULT),
   parameter int              VSHIFT   = INT_VSHIFT_DEFAULT
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NSRC-1:0]       irq,
   input  logic [PCW-1:0]        pcin,
   input  logic                  boundary,
   input  logic                  ie,
   input  logic                  id,
   input  logic                  eoi,
   input  logic                  mask_we,
   input  logic [NSRC-1:0]       mask_din,
   output logic [PCW-1:0]        pcout,
   output logic [PCW-1:0]        retpc,
   output logic                  taken,
   output logic [IDW(NSRC)-1:0]  active_id,
   output logic                  ienabled,
   output logic                  istatus,
   output logic [NSRC-1:0]       pending
);

   logic [NSRC-1:0] sync1_q, sync1_d;
   logic [NSRC-1:0] sync2_q, sync2_d;
   logic [NSRC-1:0] prev_q, prev_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [NSRC-1:0] inservice_q, inservice_d;
   logic [NSRC-1:0] mask_q, mask_d;
   logic            ienabled_q, ienabled_d;

   logic [NSRC-1:0]      above, elig, rise, sel_onehot, eoi_clr;
   logic [IDW(NSRC)-1:0] sel_idx, isv_idx;
   logic                 sel_valid, isv_valid;
   logic [PCW-1:0]       vector;

   prio_enc #(.N(NSRC)) u_isv_enc (
      .req   (inservice_q),
      .idx   (isv_idx),
      .valid (isv_valid)
   );

   // Only sources strictly more urgent than the current handler may pre-empt it.
   always_comb begin
      above = '1;
      if (isv_valid) begin
         for (int i = 0; i < NSRC; i++) begin
            above[i] = (i < int'(isv_idx));
         end
      end
      elig = pending_q & ~mask_q & above;
   end

   prio_enc #(.N(NSRC)) u_sel_enc (
      .req   (elig),
      .idx   (sel_idx),
      .valid (sel_valid)
   );

   always_comb begin
      taken      = boundary & ienabled_q & sel_valid;
      vector     = VECBASE + (PCW'(sel_idx) << VSHIFT);
      pcout      = taken ? vector : pcin;
      retpc      = pcin;
      sel_onehot = '0;
      if (taken) begin
         sel_onehot[sel_idx] = 1'b1;
      end
      eoi_clr = '0;
      if (eoi && isv_valid) begin
         eoi_clr[isv_idx] = 1'b1;
      end
   end

   always_comb begin
      sync1_d = irq;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      rise    = sync2_q & ~prev_q;
      // Edge sources: a fresh edge beats the take-clear. Level sources track sync2.
      pending_d   = (EDGEMASK & ((pending_q & ~sel_onehot) | rise))
                  | (~EDGEMASK & sync2_q);
      inservice_d = (inservice_q & ~eoi_clr) | sel_onehot;
      mask_d      = mask_we ? mask_din : mask_q;
      ienabled_d  = ienabled_q;
      if (ie) begin
         ienabled_d = 1'b1;
      end
      if (id || taken) begin
         ienabled_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         prev_q      <= '0;
         pending_q   <= '0;
         inservice_q <= '0;
         mask_q      <= '1;
         ienabled_q  <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         pending_q   <= pending_d;
         inservice_q <= inservice_d;
         mask_q      <= mask_d;
         ienabled_q  <= ienabled_d;
      end
   end

   assign pending   = pending_q;
   assign ienabled  = ienabled_q;
   assign istatus   = |inservice_q;
   assign active_id = isv_idx;

endmodule

// File: tb/tb_vectored_intcontrol.sv
// Directed bench for vectored_intcontrol: sources 0..6 edge-triggered, source 7 level.
module tb_vectored_intcontrol;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  irq;
   logic [15:0] pcin;
   logic        boundary, ie, id, eoi, mask_we;
   logic [7:0]  mask_din;
   logic [15:0] pcout, retpc;
   logic        taken, ienabled, istatus;
   logic [2:0]  active_id;
   logic [7:0]  pending;

   int n_checks = 0;
   int n_pass   = 0;

   vectored_intcontrol #(
      .NSRC(8), .PCW(16), .EDGEMASK(8'h7F), .VECBASE(16'hFF00), .VSHIFT(2)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .irq       (irq),
      .pcin      (pcin),
      .boundary  (boundary),
      .ie        (ie),
      .id        (id),
      .eoi       (eoi),
      .mask_we   (mask_we),
      .mask_din  (mask_din),
      .pcout     (pcout),
      .retpc     (retpc),
      .taken     (taken),
      .active_id (active_id),
      .ienabled  (ienabled),
      .istatus   (istatus),
      .pending   (pending)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Advance to the next falling edge and drop all one-cycle strobes.
   task automatic next_cycle();
      @(negedge clock);
      ie      = 1'b0;
      id      = 1'b0;
      eoi     = 1'b0;
      mask_we = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0; irq = '0; pcin = 16'h1234; boundary = 1'b0;
      ie = 1'b0; id = 1'b0; eoi = 1'b0; mask_we = 1'b0; mask_din = '0;
      #2;
      check("rst_taken",    taken,     0);
      check("rst_istatus",  istatus,   0);
      check("rst_active",   active_id, 0);
      check("rst_ienabled", ienabled,  0);
      check("rst_pending",  pending,   0);
      check("rst_pcout",    pcout,     16'h1234);

      // Single edge source 3
      next_cycle(); reset = 1'b1; ie = 1'b1; mask_we = 1'b1; mask_din = 8'h00; irq = 8'h08;
      next_cycle(); irq = '0; boundary = 1'b1; #1;
      check("t1_ienabled", ienabled, 1);
      check("t1_early0",   taken,    0);
      next_cycle(); #1;
      check("t1_early1",   taken,    0);
      check("t1_pend_lag", pending,  0);
      next_cycle(); #1;
      check("t1_pending",  pending,  8'h08);
      check("t1_taken",    taken,    1);
      check("t1_pcout",    pcout,    16'hFF0C);
      check("t1_retpc",    retpc,    16'h1234);
      next_cycle(); boundary = 1'b0; #1;
      check("t1_istatus",  istatus,   1);
      check("t1_active",   active_id, 3);
      check("t1_ien_clr",  ienabled,  0);
      check("t1_pend_clr", pending,   0);
      eoi = 1'b1;
      next_cycle(); #1;
      check("t1_eoi",      istatus,   0);

      // Simultaneous edges on 5 and 2
      pcin = 16'h0100; ie = 1'b1; irq = 8'h24;
      next_cycle(); irq = '0;
      next_cycle();
      next_cycle(); boundary = 1'b1; #1;
      check("t2_pending",  pending, 8'h24);
      check("t2_pcout2",   pcout,   16'hFF08);
      check("t2_retpc",    retpc,   16'h0100);
      next_cycle(); boundary = 1'b0; eoi = 1'b1; ie = 1'b1; #1;
      check("t2_active2",  active_id, 2);
      check("t2_pend5",    pending,   8'h20);
      next_cycle(); boundary = 1'b1; #1;
      check("t2_taken5",   taken, 1);
      check("t2_pcout5",   pcout, 16'hFF14);
      next_cycle(); boundary = 1'b0; eoi = 1'b1; #1;
      check("t2_active5",  active_id, 5);
      next_cycle(); #1;
      check("t2_idle",     istatus, 0);

      // Nesting: 4 in service, 1 pre-empts, 6 waits
      ie = 1'b1; irq = 8'h10;
      next_cycle(); irq = '0;
      next_cycle();
      next_cycle(); boundary = 1'b1; #1;
      check("t3_pcout4",   pcout, 16'hFF10);
      next_cycle(); boundary = 1'b0; ie = 1'b1; irq = 8'h42; #1;
      check("t3_active4",  active_id, 4);
      next_cycle(); irq = '0;
      next_cycle();
      next_cycle(); boundary = 1'b1; #1;
      check("t3_pend",     pending, 8'h42);
      check("t3_nest",     taken,   1);
      check("t3_pcout1",   pcout,   16'hFF04);
      next_cycle(); boundary = 1'b0; ie = 1'b1; #1;
      check("t3_active1",  active_id, 1);
      check("t3_pend6",    pending,   8'h40);
      next_cycle(); boundary = 1'b1; eoi = 1'b1; #1;
      check("t3_block_1",  taken, 0);
      next_cycle(); eoi = 1'b1; #1;
      check("t3_active4b", active_id, 4);
      check("t3_block_4",  taken,     0);
      next_cycle(); #1;
      check("t3_taken6",   taken, 1);
      check("t3_pcout6",   pcout, 16'hFF18);
      next_cycle(); boundary = 1'b0; eoi = 1'b1; #1;
      check("t3_active6",  active_id, 6);

      // Masked source still latches; unmask takes effect one cycle after the write
      next_cycle(); mask_we = 1'b1; mask_din = 8'h08; ie = 1'b1; irq = 8'h08;
      next_cycle(); irq = '0;
      next_cycle();
      next_cycle(); boundary = 1'b1; mask_we = 1'b1; mask_din = 8'h00; #1;
      check("t4_pend_msk", pending, 8'h08);
      check("t4_masked",   taken,   0);
      next_cycle(); #1;
      check("t4_unmask",   taken, 1);
      check("t4_pcout",    pcout, 16'hFF0C);
      next_cycle(); boundary = 1'b0; eoi = 1'b1; #1;
      check("t4_pend_clr", pending, 0);

      // Level source 7
      next_cycle(); ie = 1'b1; irq = 8'h80;
      next_cycle();
      next_cycle();
      next_cycle(); boundary = 1'b1; #1;
      check("t5_pending",  pending, 8'h80);
      check("t5_pcout",    pcout,   16'hFF1C);
      next_cycle(); boundary = 1'b0; eoi = 1'b1; ie = 1'b1; #1;
      check("t5_active7",  active_id, 7);
      check("t5_level",    pending,   8'h80);
      next_cycle(); boundary = 1'b1; #1;
      check("t5_retake",   taken, 1);
      check("t5_pcout2",   pcout, 16'hFF1C);
      next_cycle(); boundary = 1'b0; eoi = 1'b1; ie = 1'b1; irq = '0;
      next_cycle();
      next_cycle(); #1;
      check("t5_lag",      pending, 8'h80);
      next_cycle(); boundary = 1'b1; #1;
      check("t5_dropped",  pending, 0);
      check("t5_no_take",  taken,   0);

      // ie and id together
      check("t6_ien_pre",  ienabled, 1);
      next_cycle(); boundary = 1'b0; ie = 1'b1; id = 1'b1;
      next_cycle(); #1;
      check("t6_id_wins",  ienabled, 0);

      // Reset in the middle of a nested take
      ie = 1'b1; irq = 8'h10;
      next_cycle(); irq = '0;
      next_cycle();
      next_cycle(); boundary = 1'b1; #1;
      check("t7_pcout4",   pcout, 16'hFF10);
      next_cycle(); boundary = 1'b0; ie = 1'b1; irq = 8'h04;
      next_cycle(); irq = '0;
      next_cycle();
      next_cycle(); boundary = 1'b1; #1;
      check("t7_taken",    taken,   1);
      check("t7_istatus",  istatus, 1);
      reset = 1'b0; #1;
      check("t7_r_taken",  taken,     0);
      check("t7_r_pcout",  pcout,     16'h0100);
      check("t7_r_istat",  istatus,   0);
      check("t7_r_active", active_id, 0);
      check("t7_r_ien",    ienabled,  0);
      check("t7_r_pend",   pending,   0);
      next_cycle(); reset = 1'b1; #1;
      check("t7_post0",    taken, 0);
      next_cycle(); #1;
      check("t7_post1",    taken, 0);
      next_cycle(); #1;
      check("t7_post2",    taken, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vectored_intcontrol.md
# vectored_intcontrol

Parametrised, multi-source successor to the single-line interrupt controller in the Nandy core. It takes `NSRC` asynchronous interrupt requests, each configured as edge or level triggered, and synchronises and latches them. It selects the highest-priority eligible request at an instruction boundary and substitutes its vector for the next PC. It tracks in-service state so that a higher-priority source can pre-empt a lower-priority handler.

## Interface
Parameters:
- `NSRC`, 8, number of interrupt sources (2..16); index 0 is highest priority
- `PCW`, 16, program counter width
- `EDGEMASK`, 8'hFF, bit i = 1 makes source i edge-triggered (rising), 0 makes it level-triggered
- `VECBASE`, 16'hFF00, vector of source 0
- `VSHIFT`, 2, vector spacing; source i vector = `VECBASE + (i << VSHIFT)`, truncated to `PCW` bits

Ports:
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low
- `irq` in `NSRC`: raw asynchronous requests
- `pcin` in `PCW`: next PC from address calculation
- `boundary` in 1: high in the cycle in which the PC register loads (instruction boundary)
- `ie` in 1: set-global-enable strobe
- `id` in 1: clear-global-enable strobe
- `eoi` in 1: end-of-interrupt strobe
- `mask_we` in 1: mask write strobe
- `mask_din` in `NSRC`: new mask (1 = masked)
- `pcout` out `PCW`: `pcin`, or the vector when `taken`
- `retpc` out `PCW`: return address, equal to `pcin` (meaningful while `taken`)
- `taken` out 1: interrupt accepted this cycle
- `active_id` out clog2(`NSRC`): index of the highest in-service source
- `ienabled` out 1: global enable
- `istatus` out 1: any source in service
- `pending` out `NSRC`: pending register

## Operation
- Reset values: `sync1`, `sync2`, `prev`, `pending`, `inservice` = 0; `mask` = all ones; `ienabled` = 0. Consequences: `taken` = 0, `istatus` = 0, `active_id` = 0.
- Each `irq[i]` passes through a two-flop synchroniser (`sync1`, then `sync2`). `prev` holds the previous `sync2`.
- Pending update:
  - Edge source: `pending[i]` sets on `sync2 & ~prev`. It clears when source i is taken. Set wins over clear in the same cycle.
  - Level source: `pending[i]` = registered `sync2[i]`. It is never cleared by take.
- Masking: masked sources still latch pending but are not eligible for selection.
- Eligibility: `elig = pending & ~mask & above`. `above[i]` = 1 when i is below the index of the lowest-numbered `inservice` bit; all ones when nothing is in service.
- Take: `taken = boundary & ienabled & |elig`. Selection is the lowest eligible index. `pcout` = that source's vector.
- At the clock edge when `taken` is high:
  - `inservice[sel]` sets.
  - `ienabled` clears.
  - Edge source: `pending[sel]` clears.
- `eoi`: clears the lowest-numbered set `inservice` bit. With nothing in service, it has no effect.
- Enable control: `ie` sets `ienabled`; `id` clears it. If both are asserted, `id` wins. If `taken` is high, `ienabled` clears regardless of `ie`.
- `eoi` together with `taken`: the eoi clear uses pre-edge `inservice`, then the new bit is set.
- `mask_we` loads `mask` at the clock edge. The new mask affects eligibility from the next cycle.
- `istatus` = `|inservice`. `active_id` = index of the lowest set `inservice` bit (0 if none).

## Timing
- `irq` rising edge sampled at edge k: `pending` is visible after edge k+2. The earliest possible `taken` is in the cycle following edge k+2.
- `taken`, `pcout`, and `retpc` are combinational from registered state plus `boundary`/`pcin`, with zero latency.
- All state updates occur at the rising `clock` edge. `reset` low clears all state immediately, including mid-take. Once reset deasserts, there is no take for at least 3 cycles.
- Level source deasserted before `boundary`: no take occurs. The pending bit follows the level with 3 cycles of lag.

## Structure
- Shared package `nandy_int_pkg`:
  - `IDW(n)` function: clog2 with a minimum of 1
  - `lowest_set` function, returning index and valid flag
  - `INT_VSHIFT_DEFAULT` and `INT_VECBASE_DEFAULT` constants
- Sub-module `prio_enc #(N)`: lowest-index-first encoder. It is instantiated twice, once for `elig` and once for `inservice`.
- Synchroniser, edge detect, and state registers are written inline in `vectored_intcontrol`.

## Test plan
- Reset, then `ie`, `mask` = 8'h00, edge pulse on `irq[3]`, `boundary` high from cycle 4 -> `taken` = 1 in cycle 4; `pcout` = 16'hFF0C; `retpc` = `pcin`; then `istatus` = 1, `active_id` = 3, `ienabled` = 0, `pending[3]` = 0.
- `irq[5]` and `irq[2]` rise in the same cycle -> source 2 is taken first (`pcout` = 16'hFF08); after `eoi` and `ie`, source 5 is taken (16'hFF14).
- Source 4 in service with `ie` re-asserted, then `irq[1]` edge -> nested take to 16'hFF04 with `active_id` = 1; an `irq[6]` edge meanwhile stays pending and is not taken until both are cleared by `eoi`.
- `mask` = 8'h08, edge on `irq[3]` -> `pending[3]` = 1 and `taken` stays 0; write `mask` = 0 -> `taken` at the next `boundary`.
- Level source (`EDGEMASK` bit 7 = 0), `irq[7]` held high -> take to 16'hFF1C; after `eoi` and `ie` with `irq[7]` still high, it is taken again; after `irq[7]` drops, no take.
- `ie` and `id` in the same cycle -> `ienabled` = 0; `reset` low while `taken` = 1 -> all outputs return to their reset values immediately.
